pipe_hazard_ctrl: RTL and testbench

- Sequencing and hazard controller for the 3-stage core: Fetch, FD (decode/execute) and MW (memory/writeback).
- Drives the PC enable, the enables and synchronous flushes of the FD and MW pipeline buffers, the taken-branch PC redirect and the FD operand forwarding selects.
- Owns the handshake with a data memory that may take several cycles to respond.
- Tracks a valid bit per stage and holds the core idle for a fixed number of cycles after reset.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 40 ++++
 rtl/pipe_hazard_ctrl_fwd_unit.sv | 46 ++++
 rtl/pipe_hazard_ctrl.sv | 251 +++++++++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared types and constants for the 3-stage core sequencing/hazard control.
//   ctrl_state_t : controller FSM states (HOLD, RUN, MEM_WAIT)
//   fwd_sel_t    : operand forwarding select encoding for the FD stage
//   NOP_INST     : instruction word loaded into the FD buffer on a flush
//   fwd_select() : maps a forwarding hit plus load flag to a select code
// ---------------------------------------------------------------------------
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        HOLD     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2
    } ctrl_state_t;

    typedef enum logic [1:0] {
        FWD_RF   = 2'd0,
        FWD_ALU  = 2'd1,
        FWD_LOAD = 2'd2
    } fwd_sel_t;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    // A load result only exists after the memory stage, so a hit on a load
    // must take the load-data path rather than the ALU result.
    function automatic fwd_sel_t fwd_select(input logic hit, input logic is_load);
        fwd_sel_t sel;
        if (!hit) begin
            sel = FWD_RF;
        end else if (is_load) begin
            sel = FWD_LOAD;
        end else begin
            sel = FWD_ALU;
        end
        return sel;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_unit.sv
// ---------------------------------------------------------------------------
// fwd_unit
// Combinational forwarding compare for one FD source operand against the
// instruction currently in MW.
// Ports:
//   rs_i         : source register index of the FD instruction
//   use_rs_i     : FD instruction actually reads this operand
//   mw_valid_i   : MW stage holds a real (non-bubble) instruction
//   mw_reg_wr_i  : MW instruction writes the register file
//   mw_rd_i      : MW destination register index
//   mw_is_load_i : MW instruction is a load
//   sel_o        : forwarding select (FWD_RF / FWD_ALU / FWD_LOAD)
// ---------------------------------------------------------------------------
module fwd_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned REG_INDEX_WIDTH = 5
) (
    input  logic [REG_INDEX_WIDTH-1:0] rs_i,
    input  logic                       use_rs_i,
    input  logic                       mw_valid_i,
    input  logic                       mw_reg_wr_i,
    input  logic [REG_INDEX_WIDTH-1:0] mw_rd_i,
    input  logic                       mw_is_load_i,
    output fwd_sel_t                   sel_o
);

    logic hit_s;

    // Operand match against MW; x0 is hardwired to zero and never forwarded.
    always_comb begin
        hit_s = 1'b0;
        if (use_rs_i && mw_valid_i && mw_reg_wr_i &&
            (mw_rd_i == rs_i) && (rs_i != {REG_INDEX_WIDTH{1'b0}})) begin
            hit_s = 1'b1;
        end else begin
            hit_s = 1'b0;
        end
    end

    // Select encoding from hit and load flag.
    always_comb begin
        sel_o = fwd_select(hit_s, mw_is_load_i);
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
// Sequencing and hazard controller for the Fetch / FD / MW core.
// Holds the core frozen for RST_HOLD_CYCLES after reset, freezes on a
// multi-cycle data-memory access, redirects the PC on a taken branch with a
// one-cycle flush, and drives FD operand forwarding selects.
// Optional build macro: PIPE_HAZARD_CTRL_PERF_EN adds stall/flush/retire
// performance counters (stall_cnt_o, flush_cnt_o, retire_cnt_o).
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   fd_rs1_i/fd_rs2_i   : FD source register indices
//   fd_use_rs1_i/rs2_i  : FD instruction reads rs1/rs2
//   fd_br_taken_i       : raw taken decision from the branch comparator
//   mw_rd_i, mw_reg_wr_i, mw_is_load_i, mw_mem_i : MW instruction info
//   mem_ready_i         : data memory completes this cycle
//   mem_req_o           : data memory request
//   pc_en_o, pc_redirect_o          : PC enable and PC mux select
//   fd_en_o, fd_flush_o             : FD buffer enable / clear to NOP
//   mw_en_o, mw_bubble_o            : MW buffer enable / load bubble
//   fwd_a_o, fwd_b_o                : rs1/rs2 forwarding selects
//   stall_o                         : pipeline frozen this cycle
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned RST_HOLD_CYCLES = 4,
    parameter int unsigned REG_INDEX_WIDTH = 5,
    parameter int unsigned CNT_WIDTH       = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [REG_INDEX_WIDTH-1:0] fd_rs1_i,
    input  logic [REG_INDEX_WIDTH-1:0] fd_rs2_i,
    input  logic                       fd_use_rs1_i,
    input  logic                       fd_use_rs2_i,
    input  logic                       fd_br_taken_i,
    input  logic [REG_INDEX_WIDTH-1:0] mw_rd_i,
    input  logic                       mw_reg_wr_i,
    input  logic                       mw_is_load_i,
    input  logic                       mw_mem_i,
    input  logic                       mem_ready_i,
    output logic                       mem_req_o,
    output logic                       pc_en_o,
    output logic                       pc_redirect_o,
    output logic                       fd_en_o,
    output logic                       fd_flush_o,
    output logic                       mw_en_o,
    output logic                       mw_bubble_o,
    output logic [1:0]                 fwd_a_o,
    output logic [1:0]                 fwd_b_o,
    output logic                       stall_o
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    ,
    output logic [CNT_WIDTH-1:0]       stall_cnt_o,
    output logic [CNT_WIDTH-1:0]       flush_cnt_o,
    output logic [CNT_WIDTH-1:0]       retire_cnt_o
`endif
);

    localparam int unsigned HOLD_W = (RST_HOLD_CYCLES > 1) ? $clog2(RST_HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RST_HOLD_CYCLES - 1);

    // Elaboration-time parameter sanity checks.
    if (RST_HOLD_CYCLES < 1) begin : g_hold_check
        $error("RST_HOLD_CYCLES must be at least 1");
    end
    if (CNT_WIDTH < 1) begin : g_cnt_check
        $error("CNT_WIDTH must be at least 1");
    end

    ctrl_state_t       state_r;
    ctrl_state_t       state_nxt_s;
    logic [HOLD_W-1:0] hold_cnt_r;
    logic [HOLD_W-1:0] hold_cnt_nxt_s;
    logic              fd_valid_r;
    logic              mw_valid_r;

    logic              in_hold_s;
    logic              mem_pend_s;
    logic              mem_wait_s;
    logic              stall_s;
    logic              redirect_s;
    fwd_sel_t          fwd_a_s;
    fwd_sel_t          fwd_b_s;

    // Freeze and redirect conditions shared by FSM, valid tracking and outputs.
    always_comb begin
        in_hold_s  = (state_r == HOLD);
        mem_pend_s = mw_valid_r & mw_mem_i;
        // A zero-wait memory (ready in the request cycle) never freezes.
        mem_wait_s = mem_pend_s & ~mem_ready_i;
        stall_s    = in_hold_s | mem_wait_s;
        // A branch seen while frozen simply waits; fd_valid_r and the FD
        // buffer are held, so it fires on the first unfrozen cycle.
        redirect_s = fd_br_taken_i & fd_valid_r & ~stall_s;
    end

    // FSM next-state and post-reset hold countdown.
    always_comb begin
        state_nxt_s    = state_r;
        hold_cnt_nxt_s = hold_cnt_r;
        case (state_r)
            HOLD: begin
                if (hold_cnt_r == {HOLD_W{1'b0}}) begin
                    state_nxt_s = RUN;
                end else begin
                    hold_cnt_nxt_s = hold_cnt_r - HOLD_W'(1);
                end
            end
            RUN: begin
                if (mem_wait_s) begin
                    state_nxt_s = MEM_WAIT;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            MEM_WAIT: begin
                if (mem_wait_s) begin
                    state_nxt_s = MEM_WAIT;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            default: begin
                state_nxt_s    = HOLD;
                hold_cnt_nxt_s = HOLD_INIT;
            end
        endcase
    end

    // State register, hold counter and per-stage valid bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= HOLD;
            hold_cnt_r <= HOLD_INIT;
            fd_valid_r <= 1'b0;
            mw_valid_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            hold_cnt_r <= hold_cnt_nxt_s;
            if (!stall_s) begin
                // A redirect flushes FD, so the slot behind the branch is empty.
                fd_valid_r <= ~redirect_s;
                mw_valid_r <= fd_valid_r;
            end else begin
                fd_valid_r <= fd_valid_r;
                mw_valid_r <= mw_valid_r;
            end
        end
    end

    // Per-operand forwarding compare.
    fwd_unit #(
        .REG_INDEX_WIDTH (REG_INDEX_WIDTH)
    ) u_fwd_a (
        .rs_i         (fd_rs1_i),
        .use_rs_i     (fd_use_rs1_i),
        .mw_valid_i   (mw_valid_r),
        .mw_reg_wr_i  (mw_reg_wr_i),
        .mw_rd_i      (mw_rd_i),
        .mw_is_load_i (mw_is_load_i),
        .sel_o        (fwd_a_s)
    );

    fwd_unit #(
        .REG_INDEX_WIDTH (REG_INDEX_WIDTH)
    ) u_fwd_b (
        .rs_i         (fd_rs2_i),
        .use_rs_i     (fd_use_rs2_i),
        .mw_valid_i   (mw_valid_r),
        .mw_reg_wr_i  (mw_reg_wr_i),
        .mw_rd_i      (mw_rd_i),
        .mw_is_load_i (mw_is_load_i),
        .sel_o        (fwd_b_s)
    );

    // Pipeline control outputs derived from the freeze/redirect decision.
    always_comb begin
        mem_req_o     = 1'b0;
        pc_en_o       = 1'b0;
        fd_en_o       = 1'b0;
        mw_en_o       = 1'b0;
        pc_redirect_o = 1'b0;
        fd_flush_o    = 1'b0;
        mw_bubble_o   = 1'b0;
        if (in_hold_s) begin
            mem_req_o = 1'b0;
        end else begin
            // Request stays up through MEM_WAIT because MW is frozen.
            mem_req_o = mem_pend_s;
        end
        if (!stall_s) begin
            pc_en_o       = 1'b1;
            fd_en_o       = 1'b1;
            mw_en_o       = 1'b1;
            pc_redirect_o = redirect_s;
            fd_flush_o    = redirect_s;
            // An empty FD slot must not write a register or memory in MW.
            mw_bubble_o   = ~fd_valid_r;
        end else begin
            pc_en_o       = 1'b0;
            fd_en_o       = 1'b0;
            mw_en_o       = 1'b0;
            pc_redirect_o = 1'b0;
            fd_flush_o    = 1'b0;
            mw_bubble_o   = 1'b0;
        end
        stall_o = stall_s;
        fwd_a_o = fwd_a_s;
        fwd_b_o = fwd_b_s;
    end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    logic [CNT_WIDTH-1:0] stall_cnt_r;
    logic [CNT_WIDTH-1:0] flush_cnt_r;
    logic [CNT_WIDTH-1:0] retire_cnt_r;

    // Performance counters; memory-wait stalls only, wrap naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_r  <= {CNT_WIDTH{1'b0}};
            flush_cnt_r  <= {CNT_WIDTH{1'b0}};
            retire_cnt_r <= {CNT_WIDTH{1'b0}};
        end else begin
            if (stall_s && !in_hold_s) begin
                stall_cnt_r <= stall_cnt_r + CNT_WIDTH'(1);
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (redirect_s) begin
                flush_cnt_r <= flush_cnt_r + CNT_WIDTH'(1);
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
            if (mw_valid_r && !stall_s) begin
                retire_cnt_r <= retire_cnt_r + CNT_WIDTH'(1);
            end else begin
                retire_cnt_r <= retire_cnt_r;
            end
        end
    end

    // Counter output drive.
    always_comb begin
        stall_cnt_o  = stall_cnt_r;
        flush_cnt_o  = flush_cnt_r;
        retire_cnt_o = retire_cnt_r;
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Directed-vector bench for pipe_hazard_ctrl. The stimulus process drives
// one cycle of inputs and pushes the hand-computed expected outputs into a
// scoreboard queue; the monitor pops and compares on the falling edge.
// Expected vector layout: {mem_req, pc_en, redirect, fd_en, flush, mw_en,
//                          bubble, fwd_a[1:0], fwd_b[1:0], stall}
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    logic       clk;
    logic       reset;
    logic [4:0] fd_rs1_i;
    logic [4:0] fd_rs2_i;
    logic       fd_use_rs1_i;
    logic       fd_use_rs2_i;
    logic       fd_br_taken_i;
    logic [4:0] mw_rd_i;
    logic       mw_reg_wr_i;
    logic       mw_is_load_i;
    logic       mw_mem_i;
    logic       mem_ready_i;
    logic       mem_req_o;
    logic       pc_en_o;
    logic       pc_redirect_o;
    logic       fd_en_o;
    logic       fd_flush_o;
    logic       mw_en_o;
    logic       mw_bubble_o;
    logic [1:0] fwd_a_o;
    logic [1:0] fwd_b_o;
    logic       stall_o;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    logic [31:0] stall_cnt_o;
    logic [31:0] flush_cnt_o;
    logic [31:0] retire_cnt_o;
`endif

    pipe_hazard_ctrl #(
        .RST_HOLD_CYCLES (4),
        .REG_INDEX_WIDTH (5),
        .CNT_WIDTH       (32)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .fd_rs1_i      (fd_rs1_i),
        .fd_rs2_i      (fd_rs2_i),
        .fd_use_rs1_i  (fd_use_rs1_i),
        .fd_use_rs2_i  (fd_use_rs2_i),
        .fd_br_taken_i (fd_br_taken_i),
        .mw_rd_i       (mw_rd_i),
        .mw_reg_wr_i   (mw_reg_wr_i),
        .mw_is_load_i  (mw_is_load_i),
        .mw_mem_i      (mw_mem_i),
        .mem_ready_i   (mem_ready_i),
        .mem_req_o     (mem_req_o),
        .pc_en_o       (pc_en_o),
        .pc_redirect_o (pc_redirect_o),
        .fd_en_o       (fd_en_o),
        .fd_flush_o    (fd_flush_o),
        .mw_en_o       (mw_en_o),
        .mw_bubble_o   (mw_bubble_o),
        .fwd_a_o       (fwd_a_o),
        .fwd_b_o       (fwd_b_o),
        .stall_o       (stall_o)
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        ,
        .stall_cnt_o   (stall_cnt_o),
        .flush_cnt_o   (flush_cnt_o),
        .retire_cnt_o  (retire_cnt_o)
`endif
    );

    typedef struct {
        string       name;
        logic [11:0] exp;
        logic [31:0] stall_cnt;
        logic [31:0] flush_cnt;
    } sb_item_t;

    sb_item_t sb_q[$];
    int       n_checks;
    int       n_fails;
    logic [31:0] tally_stall;
    logic [31:0] tally_flush;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected-output builder: enables are the inverse of stall, flush follows redirect.
    function automatic logic [11:0] ev(input logic mr, input logic rd, input logic bb,
                                       input logic [1:0] fa, input logic [1:0] fb,
                                       input logic st);
        return {mr, ~st, rd, ~st, rd, ~st, bb, fa, fb, st};
    endfunction

    // Drive one cycle of stimulus and queue its expected response.
    task automatic step(input string nm, input logic rst,
                        input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2, input logic br,
                        input logic [4:0] rd, input logic wr, input logic ld,
                        input logic mem, input logic rdy,
                        input logic [11:0] exp);
        sb_item_t it;
        @(posedge clk);
        #1;
        reset         = rst;
        fd_rs1_i      = rs1;
        fd_rs2_i      = rs2;
        fd_use_rs1_i  = u1;
        fd_use_rs2_i  = u2;
        fd_br_taken_i = br;
        mw_rd_i       = rd;
        mw_reg_wr_i   = wr;
        mw_is_load_i  = ld;
        mw_mem_i      = mem;
        mem_ready_i   = rdy;
        it.name      = nm;
        it.exp       = exp;
        it.stall_cnt = tally_stall;
        it.flush_cnt = tally_flush;
        sb_q.push_back(it);
        // Counter effect of this cycle lands at the next edge.
        if (rst) begin
            tally_stall = 32'd0;
            tally_flush = 32'd0;
        end else begin
            // stall with a pending request is a memory stall, not HOLD
            if (exp[0] && exp[11]) tally_stall = tally_stall + 32'd1;
            if (exp[9]) tally_flush = tally_flush + 32'd1;
        end
    endtask

    // Scoreboard monitor: compare DUT outputs mid-cycle.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            sb_item_t    it;
            logic [11:0] act;
            it  = sb_q.pop_front();
            act = {mem_req_o, pc_en_o, pc_redirect_o, fd_en_o, fd_flush_o, mw_en_o,
                   mw_bubble_o, fwd_a_o, fwd_b_o, stall_o};
            n_checks = n_checks + 1;
            if (act !== it.exp) begin
                n_fails = n_fails + 1;
                $display("FAIL %s: outputs got %b expected %b", it.name, act, it.exp);
            end
`ifdef PIPE_HAZARD_CTRL_PERF_EN
            n_checks = n_checks + 1;
            if (stall_cnt_o !== it.stall_cnt || flush_cnt_o !== it.flush_cnt) begin
                n_fails = n_fails + 1;
                $display("FAIL %s_cnt: stall/flush got %0d/%0d expected %0d/%0d",
                         it.name, stall_cnt_o, flush_cnt_o, it.stall_cnt, it.flush_cnt);
            end
`endif
        end
    end

    initial begin
        n_checks      = 0;
        n_fails       = 0;
        tally_stall   = 32'd0;
        tally_flush   = 32'd0;
        reset         = 1'b1;
        fd_rs1_i      = 5'd0;
        fd_rs2_i      = 5'd0;
        fd_use_rs1_i  = 1'b0;
        fd_use_rs2_i  = 1'b0;
        fd_br_taken_i = 1'b0;
        mw_rd_i       = 5'd0;
        mw_reg_wr_i   = 1'b0;
        mw_is_load_i  = 1'b0;
        mw_mem_i      = 1'b0;
        mem_ready_i   = 1'b0;

        // Reset sampled on three edges, then four HOLD cycles.
        step("rst_a", 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, ev(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1));
        step("rst_b", 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, ev(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1));
        for (int i = 0; i < 4; i++) begin
            step($sformatf("hold_%0d", i), 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0,
                 ev(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1));
        end
        step("run_1", 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, ev(1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 1'b0));
        step("run_2", 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, ev(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0));

        // Forwarding: MW addi x5 / FD add x6,x5,x5 and variants.
        step("fwd_alu",  1'b0, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, ev(1'b0, 1'b0, 1'b0, 2'd1, 2'd1, 1'b0));
        step("fwd_x0",   1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, ev(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0));
        step("fwd_use",  1'b0, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, ev(1'b0, 1'b0, 1'b0, 2'd1, 2'd0, 1'b0));
        step("fwd_nowr", 1'b0, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, ev(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0));
        step("fwd_rs2",  1'b0, 5'd4, 5'd6, 1'b1, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, ev(1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 1'b0));

        // MW lw x7 with three wait cycles, FD addi x8,x7,1.
        for (int i = 0; i < 3; i++) begin
            step($sformatf("lw_wait_%0d", i), 1'b0, 5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0,
                 ev(1'b1, 1'b0, 1'b0, 2'd2, 2'd0, 1'b1));
        end
        step("lw_ready", 1'b0, 5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b1, 1'b1, ev(1'b1, 1'b0, 1'b0, 2'd2, 2'd0, 1'b0));

        // Taken beq: one-cycle redirect, branch enters MW, then a bubble.
        step("br_take",   1'b0, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, ev(1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0));
        step("br_bubble", 1'b0, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, ev(1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 1'b0));
        // MW empty: no request, no stall, no forwarding despite matching fields.
        step("mw_empty",  1'b0, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, ev(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0));

        // Branch taken while a store waits two cycles.
        for (int i = 0; i < 2; i++) begin
            step($sformatf("st_wait_%0d", i), 1'b0, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0,
                 ev(1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1));
        end
        step("st_ready", 1'b0, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, ev(1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0));
        step("st_after", 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, ev(1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 1'b0));
        step("refill",   1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, ev(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0));

        // Reset asserted during a memory wait.
        step("lw2_wait",    1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, ev(1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1));
        step("rst_in_wait", 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, ev(1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1));
        for (int i = 0; i < 4; i++) begin
            step($sformatf("rehold_%0d", i), 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0,
                 ev(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1));
        end
        step("rerun_1", 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, ev(1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 1'b0));
        step("rerun_2", 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, ev(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0));
        // Zero-wait memory completes in the request cycle without stalling.
        step("zero_wait", 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, ev(1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0));

        @(posedge clk);
        @(negedge clk);
        #1;
        n_checks = n_checks + 1;
        if (sb_q.size() != 0) begin
            n_fails = n_fails + 1;
            $display("FAIL sb_drain: pending entries %0d expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
